// File: rtl/bnn_pkg.sv
// Shared BNN constants and the image loader state encoding.
package bnn_pkg;

   localparam int unsigned IMG_WIDTH    = 30;
   localparam int unsigned IMG_SIZE     = IMG_WIDTH * IMG_WIDTH;
   localparam int unsigned KERNEL_WIDTH = 3;
   localparam int unsigned KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH;
   localparam int unsigned BNN1_CHANL   = 16;
   localparam int unsigned BNN2_CHANL   = 32;
   localparam int unsigned IN_WIDTH     = 8;
   localparam int unsigned NUM_BEATS    = (IMG_SIZE + IN_WIDTH - 1) / IN_WIDTH;

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } loader_state_t;

endpackage

// File: rtl/bnn_image_loader.sv
// Assembles a binary image from packed input beats into a flat buffer and
// holds it until the downstream network consumes the frame.
module bnn_image_loader #(
   parameter int unsigned IMG_WIDTH = bnn_pkg::IMG_WIDTH,
   parameter int unsigned IN_WIDTH  = bnn_pkg::IN_WIDTH,
   localparam int unsigned IMG_SIZE  = IMG_WIDTH * IMG_WIDTH,
   localparam int unsigned NUM_BEATS = (IMG_SIZE + IN_WIDTH - 1) / IN_WIDTH,
   localparam int unsigned CNT_W     = $clog2(NUM_BEATS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_valid,
   input  logic                in_sof,
   output logic                in_ready,
   output logic [IMG_SIZE-1:0] buff,
   output logic                img_valid,
   input  logic                img_ready,
   output logic [CNT_W-1:0]    beat_cnt
);

   import bnn_pkg::loader_state_t;
   import bnn_pkg::LOAD;
   import bnn_pkg::FULL;

   localparam int unsigned IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam int unsigned JW    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

   loader_state_t       state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                img_valid_q, img_valid_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]    beat_idx;
   logic                accept;
   logic [IMG_SIZE-1:0] buff_q;

   // Next-state, beat acceptance and counter update
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      accept      = 1'b0;
      beat_idx    = beat_cnt_q;
      in_ready_d  = 1'b1;
      img_valid_d = 1'b0;
      case (state_q)
         LOAD: begin
            accept   = in_valid && in_ready_q;
            beat_idx = in_sof ? '0 : beat_cnt_q;
            if (accept) begin
               if (beat_idx == CNT_W'(NUM_BEATS - 1)) begin
                  beat_cnt_d = '0;
                  state_d    = FULL;
               end else begin
                  beat_cnt_d = beat_idx + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (img_ready) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
      in_ready_d  = (state_d == LOAD);
      img_valid_d = (state_d == FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         in_ready_q  <= 1'b1;
         img_valid_q <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         img_valid_q <= img_valid_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   // Beat k lands at buff[k*IN_WIDTH +: IN_WIDTH]; bits past the image are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         buff_q <= '0;
      end else if (accept) begin
         for (int unsigned j = 0; j < IN_WIDTH; j++) begin
            if (32'(beat_idx) * IN_WIDTH + j < IMG_SIZE) begin
               buff_q[IDX_W'(32'(beat_idx) * IN_WIDTH + j)] <= in_data[JW'(j)];
            end
         end
      end
   end

   assign buff      = buff_q;
   assign in_ready  = in_ready_q;
   assign img_valid = img_valid_q;
   assign beat_cnt  = beat_cnt_q;

endmodule
